timing_pattern_gen: RTL

TIMING_PATTERN_GEN -- requirements
Module: timing_pattern_gen

---
 rtl/linebuf_pkg.sv | 19 +
 rtl/tpg_counter.sv | 36 +++
 rtl/timing_pattern_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/linebuf_pkg.sv
// Shared definitions for the timing pattern generator: FSM states,
// pattern-select codes and default field widths.
package linebuf_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } tpg_state_e;

   localparam logic [1:0] PatHorRamp = 2'b00;
   localparam logic [1:0] PatVerRamp = 2'b01;
   localparam logic [1:0] PatCount   = 2'b10;
   localparam logic [1:0] PatCheck   = 2'b11;

   localparam int unsigned DefVerWidth = 6;
   localparam int unsigned DefHorWidth = 6;
   localparam int unsigned DefRgbWidth = 10;

endpackage

// File: rtl/tpg_counter.sv
// Wrapping up-counter: counts 0..term_i, wraps to 0, synchronous clear.
module tpg_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] term_i,
   output logic [Width-1:0] cnt_o,
   output logic             wrap_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   assign wrap_o = en_i && (cnt_q == term_i);
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/timing_pattern_gen.sv
// Video timing generator with built-in test patterns; timing fields and
// pattern select are sampled only at frame start, outputs are registered.
module timing_pattern_gen
   import linebuf_pkg::*;
#(
   parameter int unsigned VER_WIDTH = DefVerWidth,
   parameter int unsigned HOR_WIDTH = DefHorWidth,
   parameter int unsigned RGB_WIDTH = DefRgbWidth
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_en,
   input  logic [VER_WIDTH-1:0] i_vsw,
   input  logic [VER_WIDTH-1:0] i_vbp,
   input  logic [VER_WIDTH-1:0] i_vact,
   input  logic [VER_WIDTH-1:0] i_vfp,
   input  logic [HOR_WIDTH-1:0] i_hsw,
   input  logic [HOR_WIDTH-1:0] i_hbp,
   input  logic [HOR_WIDTH-1:0] i_hact,
   input  logic [HOR_WIDTH-1:0] i_hfp,
   input  logic [1:0]           i_pat_sel,
   output logic                 o_vsync,
   output logic                 o_hsync,
   output logic                 o_de,
   output logic [RGB_WIDTH-1:0] o_r_data,
   output logic [RGB_WIDTH-1:0] o_g_data,
   output logic [RGB_WIDTH-1:0] o_b_data
);

   localparam int unsigned HW = HOR_WIDTH + 2;
   localparam int unsigned VW = VER_WIDTH + 2;
   localparam int unsigned CW = HOR_WIDTH + VER_WIDTH;
   localparam int unsigned PW = 4 * HOR_WIDTH + 4 * VER_WIDTH + 2;

   tpg_state_e           state_q, state_d;
   logic [PW-1:0]        par_q, par_d, par_in;
   logic [CW-1:0]        pix_cnt_q, pix_cnt_d;
   logic                 hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic [RGB_WIDTH-1:0] data_q, data_d;

   logic [1:0]           pat_l;
   logic [HOR_WIDTH-1:0] hsw_l, hbp_l, hact_l, hfp_l;
   logic [VER_WIDTH-1:0] vsw_l, vbp_l, vact_l, vfp_l;
   logic [HW-1:0]        htot_in, htot_l, hcnt, h_lo, h_hi;
   logic [VW-1:0]        vtot_in, vtot_l, vcnt, v_lo, v_hi;
   logic                 run, start_ok, h_wrap, frame_end, h_in, v_in;
   logic [HOR_WIDTH-1:0] x;
   logic [VER_WIDTH-1:0] y;

   // All timing fields plus pattern select travel as one latched word.
   assign par_in = {i_pat_sel, i_vsw, i_vbp, i_vact, i_vfp, i_hsw, i_hbp, i_hact, i_hfp};
   assign {pat_l, vsw_l, vbp_l, vact_l, vfp_l, hsw_l, hbp_l, hact_l, hfp_l} = par_q;

   assign htot_in  = HW'(i_hsw) + HW'(i_hbp) + HW'(i_hact) + HW'(i_hfp);
   assign vtot_in  = VW'(i_vsw) + VW'(i_vbp) + VW'(i_vact) + VW'(i_vfp);
   assign htot_l   = HW'(hsw_l) + HW'(hbp_l) + HW'(hact_l) + HW'(hfp_l);
   assign vtot_l   = VW'(vsw_l) + VW'(vbp_l) + VW'(vact_l) + VW'(vfp_l);
   assign start_ok = i_en && (htot_in != '0) && (vtot_in != '0);
   assign run      = (state_q == StRun);

   tpg_counter #(.Width(HW)) u_hcnt (
      .clk    (clk),
      .rstn   (rstn),
      .clr_i  (!run),
      .en_i   (run),
      .term_i (htot_l - HW'(1)),
      .cnt_o  (hcnt),
      .wrap_o (h_wrap)
   );

   tpg_counter #(.Width(VW)) u_vcnt (
      .clk    (clk),
      .rstn   (rstn),
      .clr_i  (!run),
      .en_i   (run && h_wrap),
      .term_i (vtot_l - VW'(1)),
      .cnt_o  (vcnt),
      .wrap_o (frame_end)
   );

   assign h_lo = HW'(hsw_l) + HW'(hbp_l);
   assign h_hi = h_lo + HW'(hact_l);
   assign v_lo = VW'(vsw_l) + VW'(vbp_l);
   assign v_hi = v_lo + VW'(vact_l);
   assign h_in = (hcnt >= h_lo) && (hcnt < h_hi);
   assign v_in = (vcnt >= v_lo) && (vcnt < v_hi);
   assign x    = HOR_WIDTH'(hcnt - h_lo);
   assign y    = VER_WIDTH'(vcnt - v_lo);

   always_comb begin
      state_d = state_q;
      par_d   = par_q;
      case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = StRun;
               par_d   = par_in;
            end
         end
         StRun: begin
            if (frame_end) begin
               if (start_ok) par_d = par_in;
               else          state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      hsync_d   = 1'b0;
      vsync_d   = 1'b0;
      de_d      = 1'b0;
      data_d    = '0;
      pix_cnt_d = '0;
      if (run) begin
         hsync_d = hcnt < HW'(hsw_l);
         vsync_d = vcnt < VW'(vsw_l);
         de_d    = h_in && v_in;
         if (!frame_end) pix_cnt_d = pix_cnt_q + CW'(de_d);
         if (de_d) begin
            case (pat_l)
               PatHorRamp: data_d = RGB_WIDTH'(x);
               PatVerRamp: data_d = RGB_WIDTH'(y);
               PatCount:   data_d = RGB_WIDTH'(pix_cnt_q);
               default:    data_d = (x[0] ^ y[0]) ? '1 : '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         par_q     <= '0;
         pix_cnt_q <= '0;
         hsync_q   <= 1'b0;
         vsync_q   <= 1'b0;
         de_q      <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         par_q     <= par_d;
         pix_cnt_q <= pix_cnt_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         de_q      <= de_d;
         data_q    <= data_d;
      end
   end

   assign o_hsync  = hsync_q;
   assign o_vsync  = vsync_q;
   assign o_de     = de_q;
   assign o_r_data = data_q;
   assign o_g_data = data_q;
   assign o_b_data = data_q;

endmodule
